// File: rtl/int_to_float_encoder.sv
// int_to_float_encoder: converts a 32-bit integer to an IEEE-754 single-precision pattern.
// Normalises one bit per cycle, then rounds to nearest even. Uses valid/ready on both sides.
// Optional build macro FLOAT_CLASS_OUT_EN adds a registered float_type[4:0] class output.
module int_to_float_encoder #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] int_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] float_out,
  output logic        out_valid,
  input  logic        out_ready
`ifdef FLOAT_CLASS_OUT_EN
  ,
  output logic [4:0]  float_type
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Exponent for a value whose MSB sits at bit 31: 127 + 31.
  localparam logic [7:0] EXP_TOP = 8'd158;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] float_q, float_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
`ifdef FLOAT_CLASS_OUT_EN
  logic [4:0]  ftype_q, ftype_d;
`endif

  // Rounding terms, taken from the normalised magnitude (bit 31 is the hidden one).
  logic [22:0] frac;
  logic        guard, sticky, round_up;
  logic [23:0] frac_sum;
  logic [7:0]  exp_rnd;

  assign frac     = mag_q[30:8];
  assign guard    = mag_q[7];
  assign sticky   = |mag_q[6:0];
  assign round_up = guard & (sticky | frac[0]);
  assign frac_sum = {1'b0, frac} + {23'd0, round_up};
  // A carry out of an all-ones fraction leaves frac_sum[22:0] at zero and bumps the exponent.
  assign exp_rnd  = exp_q + {7'd0, frac_sum[23]};

  // Next-state and next-output computation for the convert FSM.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    float_d     = float_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef FLOAT_CLASS_OUT_EN
    ftype_d     = ftype_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d     = SIGNED & int_in[31];
          // Negating 32'h80000000 yields itself, which is the correct unsigned magnitude.
          mag_d      = sign_d ? (~int_in + 32'd1) : int_in;
          in_ready_d = 1'b0;
          if (mag_d == 32'd0) begin
            float_d     = 32'd0;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
`ifdef FLOAT_CLASS_OUT_EN
            ftype_d     = 5'b00001;
`endif
          end else begin
            exp_d   = EXP_TOP;
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (!mag_q[31]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        float_d     = {sign_q, exp_rnd, frac_sum[22:0]};
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
`ifdef FLOAT_CLASS_OUT_EN
        ftype_d     = 5'b00010;
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 32'd0;
      exp_q       <= 8'd0;
      float_q     <= 32'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef FLOAT_CLASS_OUT_EN
      ftype_q     <= 5'b00000;
`endif
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      float_q     <= float_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef FLOAT_CLASS_OUT_EN
      ftype_q     <= ftype_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign float_out = float_q;
`ifdef FLOAT_CLASS_OUT_EN
  assign float_type = ftype_q;
`endif

endmodule

// File: tb/tb_int_to_float_encoder.sv
// Directed-vector bench for int_to_float_encoder: a signed and an unsigned instance share
// clock, reset and operand; sel chooses which one a transaction targets.
module tb_int_to_float_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] int_in;
  logic        out_ready;
  logic        in_valid_s, in_valid_u;
  logic        in_ready_s, in_ready_u;
  logic        out_valid_s, out_valid_u;
  logic [31:0] float_s, float_u;
`ifdef FLOAT_CLASS_OUT_EN
  logic [4:0]  ftype_s, ftype_u;
`endif

  bit          sel;   // 0: signed instance, 1: unsigned instance
  int          checks = 0;
  int          failures = 0;

  logic        in_ready_m, out_valid_m;
  logic [31:0] float_m;
  assign in_ready_m  = sel ? in_ready_u  : in_ready_s;
  assign out_valid_m = sel ? out_valid_u : out_valid_s;
  assign float_m     = sel ? float_u     : float_s;
`ifdef FLOAT_CLASS_OUT_EN
  logic [4:0]  ftype_m;
  assign ftype_m = sel ? ftype_u : ftype_s;
`endif

  always #5 clk = ~clk;

  int_to_float_encoder #(.SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .int_in(int_in), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .float_out(float_s), .out_valid(out_valid_s), .out_ready(out_ready)
`ifdef FLOAT_CLASS_OUT_EN
    , .float_type(ftype_s)
`endif
  );

  int_to_float_encoder #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .int_in(int_in), .in_valid(in_valid_u), .in_ready(in_ready_u),
    .float_out(float_u), .out_valid(out_valid_u), .out_ready(out_ready)
`ifdef FLOAT_CLASS_OUT_EN
    , .float_type(ftype_u)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one operand, wait (bounded) for the result, check value and latency, then
  // let the handshake complete. lat is counted in rising edges after the accept edge
  // until out_valid is seen: 0 means the result is visible right after accept.
  task automatic run_op(input bit u, input logic [31:0] v, input logic [31:0] exp_f,
                        input int exp_lat, input string tag);
    int n;
    @(negedge clk);
    sel    = u;
    int_in = v;
    if (u) in_valid_u = 1'b1; else in_valid_s = 1'b1;
    #1;
    check({tag, "_rdy"}, {31'd0, in_ready_m}, 32'd1);
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    in_valid_u = 1'b0;
    n = 0;
    while (!out_valid_m && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_val"}, float_m, exp_f);
`ifdef FLOAT_CLASS_OUT_EN
    check({tag, "_cls"}, {27'd0, ftype_m}, (exp_f[30:0] == 31'd0) ? 32'd1 : 32'd2);
`endif
    @(posedge clk); #1;
    check({tag, "_done"}, {30'd0, out_valid_m, in_ready_m}, 32'b01);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    out_ready  = 1'b1;
    int_in     = 32'd0;
    in_valid_s = 1'b0;
    in_valid_u = 1'b0;
    sel        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", {31'd0, in_ready_s}, 32'd1);
    check("rst_vld", {31'd0, out_valid_s}, 32'd0);
    check("rst_out", float_s, 32'd0);
`ifdef FLOAT_CLASS_OUT_EN
    check("rst_cls", {27'd0, ftype_s}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 32'h0000_0000, 32'h0000_0000, 0,  "zero");
    run_op(1'b0, 32'h0000_0001, 32'h3F80_0000, 33, "one");
    run_op(1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 33, "neg1");
    run_op(1'b1, 32'hFFFF_FFFF, 32'h4F80_0000, 2,  "umax");
    run_op(1'b0, 32'h7FFF_FFFF, 32'h4F00_0000, 3,  "smax");
    run_op(1'b0, 32'h8000_0000, 32'hCF00_0000, 2,  "smin");
    run_op(1'b1, 32'h8000_0000, 32'h4F00_0000, 2,  "u2p31");
    run_op(1'b0, 32'h0100_0001, 32'h4B80_0000, 9,  "tie_dn");
    run_op(1'b0, 32'h0100_0003, 32'h4B80_0002, 9,  "tie_up");
    run_op(1'b0, 32'hFFFF_FFFD, 32'hC040_0000, 32, "neg3");

    // Backpressure: result 5 -> 0x40A00000 held while out_ready is low.
    out_ready = 1'b0;
    @(negedge clk);
    sel = 1'b0; int_in = 32'd5; in_valid_s = 1'b1;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    n = 0;
    while (!out_valid_s && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_lat", 32'(n), 32'd31);
    check("bp_val", float_s, 32'h40A0_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      int_in = 32'd7; in_valid_s = 1'b1;
      @(posedge clk); #1;
      check("bp_hold", {float_s[31:2], out_valid_s, in_ready_s},
            {30'h1028_0000, 1'b1, 1'b0});
    end
    @(negedge clk);
    in_valid_s = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel", {30'd0, out_valid_s, in_ready_s}, 32'b01);
    check("bp_keep", float_s, 32'h40A0_0000);

    // Reset while normalising an operand of 1 drops it.
    @(negedge clk);
    int_in = 32'd1; in_valid_s = 1'b1;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst", {float_s[31:2], out_valid_s, in_ready_s}, 32'b01);
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 32'h0000_0003, 32'h4040_0000, 32, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
